imm_encoder: RTL and testbench

// - Inverse of the immediate extender: packs a 32-bit immediate value into the immediate bit-fields of a RISC-V instruction word.
// - Streaming block in the program-loader path; outputs encoded words with a sequential instruction-memory address.
// - Flags immediates not representable in the selected format.
// - Round-trip property: extender(imm_src, instr) == imm for every non-error word.

---
 rtl/Imm_pkg.sv | 55 +++++
 rtl/imm_pack.sv | 51 +++++
 rtl/imm_encoder.sv | 143 ++++++++++++++
 tb/tb_imm_encoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Imm_pkg.sv
// Immediate format encodings, per-format instruction bit masks and the range
// check shared by the immediate encoder.
// Pure package: no ports, no state.
package Imm_pkg;

  // Iu/Bu are the zero-extended variants of the I and B formats.
  // Encoding 3'd7 is reserved and treated as an undefined format.
  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_IU = 3'd5,
    IMM_BU = 3'd6
  } IMM_t;

  // Instruction bit positions that carry immediate bits, per format.
  localparam logic [31:0] IMM_FIELD_MASK_I = 32'hFFF0_0000; // [31:20]
  localparam logic [31:0] IMM_FIELD_MASK_S = 32'hFE00_0F80; // [31:25],[11:7]
  localparam logic [31:0] IMM_FIELD_MASK_B = 32'hFE00_0F80; // [31:25],[11:7]
  localparam logic [31:0] IMM_FIELD_MASK_U = 32'hFFFF_F000; // [31:12]
  localparam logic [31:0] IMM_FIELD_MASK_J = 32'hFFFF_F000; // [31:12]

  function automatic logic [31:0] imm_field_mask(IMM_t src);
    logic [31:0] m;
    case (src)
      IMM_I, IMM_IU: m = IMM_FIELD_MASK_I;
      IMM_S:         m = IMM_FIELD_MASK_S;
      IMM_B, IMM_BU: m = IMM_FIELD_MASK_B;
      IMM_U:         m = IMM_FIELD_MASK_U;
      IMM_J:         m = IMM_FIELD_MASK_J;
      default:       m = 32'h0;
    endcase
    return m;
  endfunction

  // True when imm is exactly what the extender would produce for some
  // instruction in format src. Signed formats need the upper bits to be a
  // pure sign extension; branch/jump offsets must be even.
  function automatic logic imm_fits(IMM_t src, logic [31:0] imm);
    logic ok;
    case (src)
      IMM_I, IMM_S: ok = (&imm[31:11]) || !(|imm[31:11]);
      IMM_IU:       ok = !(|imm[31:12]);
      IMM_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      IMM_BU:       ok = !(|imm[31:13]) && !imm[0];
      IMM_U:        ok = !(|imm[11:0]);
      IMM_J:        ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm into the format's instruction
// fields over base and flags values the format cannot represent.
// Ports: imm_src/imm/base in; instr (packed word) and err (not representable) out.
module imm_pack
  import Imm_pkg::*;
(
  input  IMM_t        imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] placed;

  always_comb begin
    placed = 32'h0;
    case (imm_src)
      IMM_I, IMM_IU: begin
        placed[31:20] = imm[11:0];
      end
      IMM_S: begin
        placed[31:25] = imm[11:5];
        placed[11:7]  = imm[4:0];
      end
      IMM_B, IMM_BU: begin
        placed[31]    = imm[12];
        placed[7]     = imm[11];
        placed[30:25] = imm[10:5];
        placed[11:8]  = imm[4:1];
      end
      IMM_U: begin
        placed[31:12] = imm[31:12];
      end
      IMM_J: begin
        placed[31]    = imm[20];
        placed[19:12] = imm[19:12];
        placed[20]    = imm[11];
        placed[30:21] = imm[10:1];
      end
      default: begin
        placed = 32'h0;
      end
    endcase
  end

  // Undefined formats have an all-zero mask, so the word passes through as base.
  assign instr = (base & ~imm_field_mask(imm_src)) | placed;
  assign err   = !imm_fits(imm_src, imm);

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: packs imm into base and tags each word with a sequential address.
// Latency: 2 cycles from input handshake to out_valid, 1 word/cycle sustained.
// Backpressure: each stage accepts when empty or when its successor accepts; a stalled output holds.
// Ports: clk, rst_n (async, active-low), clr (sync clear of address/error state);
//        in_valid/in_ready with imm_src, imm, base; out_valid/out_ready with instr,
//        out_addr, err; err_sticky and saturating err_cnt over emitted words.
module imm_encoder
  import Imm_pkg::*;
#(
  parameter int             AW        = 32,
  parameter logic [AW-1:0]  ADDR_BASE = '0,
  parameter int             CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  IMM_t             imm_src,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [AW-1:0]    out_addr,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  // S1: captured input word
  logic        s1_vld_q, s1_vld_d;
  IMM_t        s1_src_q, s1_src_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [31:0] s1_base_q, s1_base_d;

  // S2: packed word as presented on the output
  logic        s2_vld_q, s2_vld_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;

  // Address and error bookkeeping, advanced on output handshakes
  logic [AW-1:0]    addr_q, addr_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        s1_rdy, s2_rdy, out_hs;
  logic [31:0] pack_instr;
  logic        pack_err;

  imm_pack u_pack (
    .imm_src (s1_src_q),
    .imm     (s1_imm_q),
    .base    (s1_base_q),
    .instr   (pack_instr),
    .err     (pack_err)
  );

  always_comb begin
    s2_rdy = !s2_vld_q || out_ready;
    s1_rdy = !s1_vld_q || s2_rdy;
    out_hs = s2_vld_q && out_ready;

    s1_vld_d   = s1_vld_q;
    s1_src_d   = s1_src_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s2_vld_d   = s2_vld_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    addr_d     = addr_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;

    if (s1_rdy) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_src_d  = imm_src;
        s1_imm_d  = imm;
        s1_base_d = base;
      end
    end

    if (s2_rdy) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_instr_d = pack_instr;
        s2_err_d   = pack_err;
      end
    end

    // clr overrides a concurrent handshake: the word leaving now is neither
    // counted nor allowed to advance the address past ADDR_BASE.
    if (clr) begin
      addr_d   = ADDR_BASE;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (out_hs) begin
      addr_d = addr_q + AW'(4);
      if (s2_err_q) begin
        sticky_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_src_q   <= IMM_I;
      s1_imm_q   <= 32'h0;
      s1_base_q  <= 32'h0;
      s2_vld_q   <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= 1'b0;
      addr_q     <= ADDR_BASE;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_src_q   <= s1_src_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s2_vld_q   <= s2_vld_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = s1_rdy;
  assign out_valid  = s2_vld_q;
  assign instr      = s2_instr_q;
  assign err        = s2_err_q;
  assign out_addr   = addr_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
`timescale 1ns/1ps
module tb_imm_encoder;
  import Imm_pkg::*;

  logic        clk, rst_n, clr, in_valid, out_ready;
  IMM_t        imm_src;
  logic [31:0] imm, base;
  logic        in_ready, out_valid, err, err_sticky;
  logic [31:0] instr, out_addr;
  logic [7:0]  err_cnt;
  logic        w_in_ready, w_out_valid, w_err, w_err_sticky;
  logic [31:0] w_instr;
  logic [3:0]  w_out_addr;
  logic [7:0]  w_err_cnt;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_addr(out_addr), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  // Narrow-address copy fed the same stream, to exercise address wrap.
  imm_encoder #(.AW(4), .ADDR_BASE(4'hC), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
    .imm_src(imm_src), .imm(imm), .base(base), .out_valid(w_out_valid), .out_ready(out_ready),
    .instr(w_instr), .out_addr(w_out_addr), .err(w_err), .err_sticky(w_err_sticky),
    .err_cnt(w_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    IMM_t        src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
    logic        rt;     // check by round trip instead of exact word
  } item_t;

  item_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out = 0;
  logic [31:0] exp_addr;
  logic [3:0]  exp_waddr;
  logic [7:0]  exp_cnt;
  logic        exp_sticky;
  logic        stall_prev;
  logic [31:0] st_instr, st_addr;
  logic        st_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] extend(IMM_t s, logic [31:0] i);
    case (s)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_IU:  return {20'h0, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_BU:  return {19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'h0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fmask(IMM_t s);
    case (s)
      IMM_I, IMM_IU:        return 32'hFFF0_0000;
      IMM_S, IMM_B, IMM_BU: return 32'hFE00_0F80;
      IMM_U, IMM_J:         return 32'hFFFF_F000;
      default:              return 32'h0;
    endcase
  endfunction

  function automatic item_t mk(IMM_t s, logic [31:0] i, logic [31:0] b,
                               logic [31:0] ins, logic e);
    item_t it;
    it.src = s; it.imm = i; it.base = b; it.instr = ins; it.err = e; it.rt = 1'b0;
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t       it;
    logic [31:0] r;
    it.src  = IMM_t'($urandom_range(0, 6));
    r       = $urandom;
    it.base = $urandom;
    case (it.src)
      IMM_I, IMM_S: it.imm = {{20{r[11]}}, r[11:0]};
      IMM_IU:       it.imm = {20'h0, r[11:0]};
      IMM_B:        it.imm = {{19{r[12]}}, r[12:1], 1'b0};
      IMM_BU:       it.imm = {19'h0, r[12:1], 1'b0};
      IMM_U:        it.imm = {r[31:12], 12'h0};
      default:      it.imm = {{11{r[20]}}, r[20:1], 1'b0};
    endcase
    it.instr = 32'h0; it.err = 1'b0; it.rt = 1'b1;
    return it;
  endfunction

  task automatic reset_model();
    exp_addr = 32'h0; exp_waddr = 4'hC; exp_cnt = 8'h0; exp_sticky = 1'b0;
    stall_prev = 1'b0;
  endtask

  // One clock: drive at the falling edge, then score what the next rising
  // edge will transfer on both handshakes.
  task automatic drive(input logic iv, input item_t it, input logic ordy,
                       input logic clr_v, output logic hs);
    item_t e;
    @(negedge clk);
    in_valid = iv; imm_src = it.src; imm = it.imm; base = it.base;
    out_ready = ordy; clr = clr_v;
    #1;
    if (stall_prev) begin
      check("stall_vld", out_valid, 1'b1);
      check("stall_instr", instr, st_instr);
      check("stall_addr", out_addr, st_addr);
      check("stall_err", err, st_err);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        if (e.rt) begin
          check("rt_ext", extend(e.src, instr), e.imm);
          check("rt_base", instr & ~fmask(e.src), e.base & ~fmask(e.src));
        end else begin
          check("instr", instr, e.instr);
          check("w_instr", w_instr, e.instr);
          check("w_err", w_err, e.err);
        end
        check("err", err, e.err);
        check("addr", out_addr, exp_addr);
        check("w_vld", w_out_valid, 1'b1);
        check("w_addr", w_out_addr, exp_waddr);
        check("err_cnt", err_cnt, exp_cnt);
        check("err_sticky", err_sticky, exp_sticky);
        check("w_err_cnt", w_err_cnt, exp_cnt);
        check("w_err_sticky", w_err_sticky, exp_sticky);
        n_out++;
        if (!clr_v) begin
          exp_addr  = exp_addr + 32'd4;
          exp_waddr = exp_waddr + 4'd4;
          if (e.err) begin
            exp_sticky = 1'b1;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
          end
        end
      end
    end
    if (clr_v) begin
      exp_addr = 32'h0; exp_waddr = 4'hC; exp_cnt = 8'h0; exp_sticky = 1'b0;
    end
    stall_prev = out_valid && !out_ready;
    st_instr = instr; st_addr = out_addr; st_err = err;
    hs = iv && in_ready;
    if (hs) exp_q.push_back(it);
  endtask

  task automatic drain();
    item_t idle;
    logic  hs;
    idle = mk(IMM_I, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) drive(1'b0, idle, 1'b1, 1'b0, hs);
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    item_t idle, it;
    logic  hs;
    int    sent, cyc, out0;

    idle = mk(IMM_I, 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = IMM_I; imm = 32'h0; base = 32'h0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_cnt", err_cnt, 8'h0);
    check("rst_addr", out_addr, 32'h0);
    check("rst_w_addr", w_out_addr, 4'hC);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_w_in_ready", w_in_ready, 1'b1);
    rst_n = 1'b1;

    // Latency and basic encodes
    drive(1'b1, mk(IMM_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0), 1'b1, 1'b0, hs);
    check("lat_hs", hs, 1'b1);
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    check("lat_c1_vld", out_valid, 1'b0);
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    check("lat_c2_vld", out_valid, 1'b1);
    drive(1'b1, mk(IMM_B, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_S, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_J, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_BU, 32'h0000_1FFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_IU, 32'h0000_0FFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0), 1'b1, 1'b0, hs);
    drain();
    check("no_err_sticky", err_sticky, 1'b0);

    // Range errors: word still emitted, counted on handshake
    drive(1'b1, mk(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1), 1'b1, 1'b0, hs);
    drain();
    check("err1_sticky", err_sticky, 1'b1);
    check("err1_cnt", err_cnt, 8'd1);
    drive(1'b1, mk(IMM_J, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1), 1'b1, 1'b0, hs);
    drain();
    check("err2_cnt", err_cnt, 8'd2);
    drive(1'b1, mk(IMM_t'(3'd7), 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b1), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_U, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1), 1'b1, 1'b0, hs);
    drain();
    check("err4_cnt", err_cnt, 8'd4);

    // Burst of 8 with a 3-cycle output stall in the middle
    out0 = n_out; sent = 0;
    for (cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
      it = mk(IMM_U, (sent + 1) * 32'h1111_1000, 32'h0000_0037,
              ((sent + 1) * 32'h1111_1000) | 32'h37, 1'b0);
      drive(sent < 8, it, !(cyc >= 3 && cyc < 6), 1'b0, hs);
      if (hs) sent++;
    end
    drain();
    check("burst_count", n_out - out0, 8);

    // Random legal round trips
    sent = 0;
    it = rand_item();
    for (cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      drive($urandom_range(0, 4) != 0, it, $urandom_range(0, 3) != 0, 1'b0, hs);
      if (hs) begin
        sent++;
        it = rand_item();
      end
    end
    check("rand_sent", sent, 10000);
    drain();

    // clr concurrent with an error word's output handshake
    drive(1'b1, mk(IMM_I, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1), 1'b1, 1'b0, hs);
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    drive(1'b0, idle, 1'b1, 1'b1, hs);
    check("clr_hs_vld", out_valid, 1'b1);
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    check("clr_addr", out_addr, 32'h0);
    check("clr_w_addr", w_out_addr, 4'hC);
    check("clr_cnt", err_cnt, 8'd0);
    check("clr_sticky", err_sticky, 1'b0);
    drive(1'b1, mk(IMM_U, 32'hABCD_E000, 32'h0000_0037, 32'hABCD_E037, 1'b0), 1'b1, 1'b0, hs);
    drain();
    check("post_clr_addr", out_addr, 32'h4);

    // Reset with two words in flight
    drive(1'b1, mk(IMM_U, 32'h1000_0000, 32'h0000_0037, 32'h1000_0037, 1'b0), 1'b1, 1'b0, hs);
    drive(1'b1, mk(IMM_U, 32'h2000_0000, 32'h0000_0037, 32'h2000_0037, 1'b0), 1'b1, 1'b0, hs);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("inflight_vld", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_vld", out_valid, 1'b0);
    check("arst_w_vld", w_out_valid, 1'b0);
    exp_q.delete();
    reset_model();
    drive(1'b0, idle, 1'b1, 1'b0, hs);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, idle, 1'b1, 1'b0, hs);
      check("post_rst_vld", out_valid, 1'b0);
    end
    check("post_rst_addr", out_addr, 32'h0);
    check("post_rst_w_addr", w_out_addr, 4'hC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
